offset_range_check: RTL and testbench



---
 rtl/offset_range_check.sv | 39 +++
 tb/tb_offset_range_check.sv | 133 +++++++++++++
 2 files changed

// File: rtl/offset_range_check.sv
// offset_range_check: unsigned inclusive window comparator [low, low+delta] with registered edge flags
module offset_range_check #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] low,
    input  logic [WIDTH-1:0] delta,
    input  logic [WIDTH-1:0] val,
    output logic             is_between,
    output logic             below,
    output logic             above,
    output logic             at_start,
    output logic             at_end,
    output logic             in_q,
    output logic             entered,
    output logic             exited
);
    logic [WIDTH:0] hi;
    always_comb begin
        hi         = {1'b0, low} + {1'b0, delta};
        below      = val < low;
        above      = {1'b0, val} > hi;
        is_between = ~below & ~above;
        at_start   = val == low;
        at_end     = {1'b0, val} == hi;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_q    <= 1'b0;
            entered <= 1'b0;
            exited  <= 1'b0;
        end else begin
            in_q    <= is_between;
            entered <= is_between & ~in_q;
            exited  <= ~is_between & in_q;
        end
    end
endmodule

// File: tb/tb_offset_range_check.sv
// tb_offset_range_check: directed checks of window decode, overflow window and registered edge flags
module tb_offset_range_check;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] low16 = 16'd192, delta16 = 16'd95, val16 = 16'd0;
    logic is_between, below, above, at_start, at_end, in_q, entered, exited;
    offset_range_check #(.WIDTH(16)) u_main (
        .clock(clock), .reset(reset), .low(low16), .delta(delta16), .val(val16),
        .is_between(is_between), .below(below), .above(above), .at_start(at_start),
        .at_end(at_end), .in_q(in_q), .entered(entered), .exited(exited));

    logic a_between, a_below, a_above, a_start, a_end, a_in_q, a_entered, a_exited;
    offset_range_check #(.WIDTH(16)) u_a (
        .clock(clock), .reset(reset), .low(16'd0), .delta(16'd191), .val(val16),
        .is_between(a_between), .below(a_below), .above(a_above), .at_start(a_start),
        .at_end(a_end), .in_q(a_in_q), .entered(a_entered), .exited(a_exited));

    logic [31:0] low32 = 32'd49600, delta32 = 32'd767999, val32 = 32'd0;
    logic w_between, w_below, w_above, w_start, w_end, w_in_q, w_entered, w_exited;
    offset_range_check #(.WIDTH(32)) u_w (
        .clock(clock), .reset(reset), .low(low32), .delta(delta32), .val(val32),
        .is_between(w_between), .below(w_below), .above(w_above), .at_start(w_start),
        .at_end(w_end), .in_q(w_in_q), .entered(w_entered), .exited(w_exited));

    logic [7:0] low8 = 8'd250, delta8 = 8'd20, val8 = 8'd0;
    logic n_between, n_below, n_above, n_start, n_end, n_in_q, n_entered, n_exited;
    offset_range_check #(.WIDTH(8)) u_n (
        .clock(clock), .reset(reset), .low(low8), .delta(delta8), .val(val8),
        .is_between(n_between), .below(n_below), .above(n_above), .at_start(n_start),
        .at_end(n_end), .in_q(n_in_q), .entered(n_entered), .exited(n_exited));

    int n_pass = 0, n_total = 0;
    logic m_in = 1'b0, m_ent = 1'b0, m_ex = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Drive one value, check the combinational decode, then the flags after the next edge.
    task automatic step(input int v);
        int lo, hi;
        logic e;
        lo = int'(low16);
        hi = int'(low16) + int'(delta16);
        val16 = v[15:0];
        #1;
        e = (v >= lo) && (v <= hi);
        chk("is_between", is_between, e);
        chk("below", below, v < lo);
        chk("above", above, v > hi);
        chk("at_start", at_start, v == lo);
        chk("at_end", at_end, v == hi);
        chk("one_hot", below + is_between + above, 1);
        @(posedge clock);
        m_ent = e & ~m_in;
        m_ex  = ~e & m_in;
        m_in  = e;
        #1;
        chk("in_q", in_q, m_in);
        chk("entered", entered, m_ent);
        chk("exited", exited, m_ex);
        chk("no_both", entered & exited, 0);
    endtask

    initial begin
        #1;
        chk("rst_in_q", in_q, 0);
        chk("rst_entered", entered, 0);
        chk("rst_exited", exited, 0);
        @(posedge clock); #1;
        chk("rst_hold_in_q", in_q, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        for (int v = 0; v < 1600; v++) begin
            step(v);
            if (v == 192) begin
                chk("b2b_a_exit", a_exited, 1);
                chk("b2b_b_enter", entered, 1);
            end
            if (v == 288) chk("exit_after_288", exited, 1);
        end

        val32 = 32'd49599;  #1; chk("w49599", w_between, 0);
        val32 = 32'd49600;  #1; chk("w49600", w_between, 1);
        val32 = 32'd817599; #1; chk("w817599", w_between, 1); chk("w817599_end", w_end, 1);
        val32 = 32'd817600; #1; chk("w817600", w_between, 0); chk("w817600_above", w_above, 1);

        val8 = 8'd255; #1;
        chk("ovf_between", n_between, 1);
        chk("ovf_above", n_above, 0);
        chk("ovf_end", n_end, 0);
        val8 = 8'd249; #1;
        chk("ovf_below", n_below, 1);
        chk("ovf_between_249", n_between, 0);
        val8 = 8'd250; #1;
        chk("ovf_start", n_start, 1);

        low16 = 16'd5; delta16 = 16'd0;
        for (int v = 3; v < 8; v++) step(v);
        step(4);
        step(5); chk("alt_enter", entered, 1);
        step(4); chk("alt_exit", exited, 1);
        step(5); chk("alt_enter2", entered, 1);
        step(4); chk("alt_exit2", exited, 1);

        low16 = 16'd192; delta16 = 16'd95;
        step(200);
        step(201);
        chk("pre_rst_in_q", in_q, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_in_q", in_q, 0);
        chk("async_entered", entered, 0);
        chk("async_exited", exited, 0);
        #1 reset = 1'b1;
        m_in = 1'b0;
        @(posedge clock); #1;
        chk("rel_in_q", in_q, 1);
        chk("rel_entered", entered, 1);
        chk("rel_exited", exited, 0);
        m_in = 1'b1;
        @(posedge clock); #1;
        chk("rel_entered_once", entered, 0);
        chk("rel_in_q_hold", in_q, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
